// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port data memory: grants one requester at a
// time and sequences each access as IDLE -> ACCESS -> DONE with a response strobe.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DMEM_WORDS = 256,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // One extra bit so DMEM_WORDS itself is representable for the range compare.
    localparam logic [ADDR_W:0] WORDS_LIM = (ADDR_W+1)'(DMEM_WORDS);

    state_t              state_q;
    logic                owner_q;      // 0 = M0, 1 = M1
    logic                last_q;       // master granted most recently
    logic                we_q;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                mem_we_q;
    logic [1:0]          gnt_q;
    logic [1:0]          rvalid_q;
    logic [1:0]          rsp_err_q;
    logic [DATA_W-1:0]   rdata_q [2];

    logic                pick_m1_d;
    logic                win_we_d;
    logic [ADDR_W-1:0]   win_addr_d;
    logic [DATA_W-1:0]   win_wdata_d;
    logic                win_in_range_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pick_m1_d = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            pick_m1_d = FIXED_PRIO ? 1'b0 : ~last_q;
        end
        win_we_d       = pick_m1_d ? m1_we_i    : m0_we_i;
        win_addr_d     = pick_m1_d ? m1_addr_i  : m0_addr_i;
        win_wdata_d    = pick_m1_d ? m1_wdata_i : m0_wdata_i;
        win_in_range_d = ({1'b0, win_addr_d} < WORDS_LIM);
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two-entry response-data array is plain flops, so it is
            // reset along with the rest; large RAM arrays would not be.
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_we_q  <= 1'b0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rsp_err_q <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        owner_q            <= pick_m1_d;
                        last_q             <= pick_m1_d;
                        we_q               <= win_we_d;
                        err_q              <= ~win_in_range_d;
                        addr_q             <= win_addr_d;
                        wdata_q            <= win_wdata_d;
                        mem_we_q           <= win_we_d & win_in_range_d;
                        gnt_q[pick_m1_d]   <= 1'b1;
                        state_q            <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    gnt_q              <= '0;
                    mem_we_q           <= 1'b0;
                    rvalid_q[owner_q]  <= 1'b1;
                    rsp_err_q[owner_q] <= err_q;
                    rdata_q[owner_q]   <= (we_q || err_q) ? '0 : mem_rdata_i;
                    state_q            <= S_DONE;
                end
                S_DONE: begin
                    rvalid_q   <= '0;
                    rsp_err_q  <= '0;
                    rdata_q[0] <= '0;
                    rdata_q[1] <= '0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = mem_we_q;

    assign m0_gnt_o    = gnt_q[0];
    assign m0_rvalid_o = rvalid_q[0];
    assign m0_rdata_o  = rdata_q[0];
    assign m0_err_o    = rsp_err_q[0];

    assign m1_gnt_o    = gnt_q[1];
    assign m1_rvalid_o = rvalid_q[1];
    assign m1_rdata_o  = rdata_q[1];
    assign m1_err_o    = rsp_err_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin instance checked cycle by cycle against a
// transaction-level model, plus a fixed-priority instance with directed checks.
module tb_dmem_arbiter;

    localparam int WORDS = 256;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- round-robin instance ----------------
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DMEM_WORDS(WORDS), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
    );

    // DMEM stub: combinational read, write on rising edge.
    logic [31:0] dmem0 [WORDS];
    assign mem_rdata = (mem_addr < WORDS) ? dmem0[mem_addr[7:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_we && mem_addr < WORDS) dmem0[mem_addr[7:0]] <= mem_wdata;

    // ---------------- fixed-priority instance ----------------
    logic        f_m0_req, f_m0_we, f_m0_gnt, f_m0_rvalid, f_m0_err;
    logic [31:0] f_m0_addr, f_m0_wdata, f_m0_rdata;
    logic        f_m1_req, f_m1_we, f_m1_gnt, f_m1_rvalid, f_m1_err;
    logic [31:0] f_m1_addr, f_m1_wdata, f_m1_rdata;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic        f_mem_we;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DMEM_WORDS(WORDS), .FIXED_PRIO(1'b1)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(f_m0_req), .m0_we_i(f_m0_we), .m0_addr_i(f_m0_addr), .m0_wdata_i(f_m0_wdata),
        .m0_gnt_o(f_m0_gnt), .m0_rvalid_o(f_m0_rvalid), .m0_rdata_o(f_m0_rdata), .m0_err_o(f_m0_err),
        .m1_req_i(f_m1_req), .m1_we_i(f_m1_we), .m1_addr_i(f_m1_addr), .m1_wdata_i(f_m1_wdata),
        .m1_gnt_o(f_m1_gnt), .m1_rvalid_o(f_m1_rvalid), .m1_rdata_o(f_m1_rdata), .m1_err_o(f_m1_err),
        .mem_addr_o(f_mem_addr), .mem_wdata_o(f_mem_wdata), .mem_we_o(f_mem_we), .mem_rdata_i(f_mem_rdata)
    );

    logic [31:0] dmemf [WORDS];
    assign f_mem_rdata = (f_mem_addr < WORDS) ? dmemf[f_mem_addr[7:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (f_mem_we && f_mem_addr < WORDS) dmemf[f_mem_addr[7:0]] <= f_mem_wdata;

    // ---------------- reference model (round-robin instance) ----------------
    // Tracks cycles since a grant (0 = free, 1 = granted cycle, 2 = response cycle)
    // and keeps its own copy of memory contents.
    logic [31:0] ref_mem [WORDS];
    int          ph;
    logic        own, last_m, lwe, exp_err;
    logic [31:0] laddr, lwdata, exp_rdata;
    logic        mdl_pick, mdl_oor;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ref_mem[i] = 32'h1000_0000 + i;
            dmem0[i]   = 32'h1000_0000 + i;
            dmemf[i]   = 32'h1000_0000 + i;
        end
    end

    assign mdl_pick = (m0_req && m1_req) ? ~last_m : m1_req;
    assign mdl_oor  = (laddr >= WORDS);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0; own <= 1'b0; last_m <= 1'b1; lwe <= 1'b0;
            laddr <= '0; lwdata <= '0; exp_rdata <= '0; exp_err <= 1'b0;
        end else if (ph == 0) begin
            if (m0_req || m1_req) begin
                own    <= mdl_pick;
                last_m <= mdl_pick;
                lwe    <= mdl_pick ? m1_we    : m0_we;
                laddr  <= mdl_pick ? m1_addr  : m0_addr;
                lwdata <= mdl_pick ? m1_wdata : m0_wdata;
                ph     <= 1;
            end
        end else if (ph == 1) begin
            exp_err   <= mdl_oor;
            exp_rdata <= (lwe || mdl_oor) ? 32'h0 : ref_mem[laddr[7:0]];
            if (lwe && !mdl_oor) ref_mem[laddr[7:0]] <= lwdata;
            ph <= 2;
        end else begin
            ph <= 0;
        end
    end

    // ---------------- compare process + event recorder ----------------
    int gnt0_cyc, gnt1_cyc, rv0_cyc, rv1_cyc;
    int gnt_cnt = 0, rv_cnt = 0, we_cnt = 0;
    logic [31:0] rv0_data, rv1_data;
    logic        rv0_err, rv1_err;
    int order [$];

    always @(negedge clk) begin
        check("m0_gnt",    m0_gnt,    (ph == 1 && !own));
        check("m1_gnt",    m1_gnt,    (ph == 1 &&  own));
        check("mem_we",    mem_we,    (ph == 1 && lwe && !mdl_oor));
        check("mem_addr",  mem_addr,  laddr);
        check("mem_wdata", mem_wdata, lwdata);
        check("m0_rvalid", m0_rvalid, (ph == 2 && !own));
        check("m1_rvalid", m1_rvalid, (ph == 2 &&  own));
        check("m0_err",    m0_err,    (ph == 2 && !own && exp_err));
        check("m1_err",    m1_err,    (ph == 2 &&  own && exp_err));
        check("m0_rdata",  m0_rdata,  (ph == 2 && !own) ? exp_rdata : 32'h0);
        check("m1_rdata",  m1_rdata,  (ph == 2 &&  own) ? exp_rdata : 32'h0);
        if (m0_gnt) begin gnt0_cyc <= cyc; order.push_back(0); gnt_cnt <= gnt_cnt + 1; end
        if (m1_gnt) begin gnt1_cyc <= cyc; order.push_back(1); gnt_cnt <= gnt_cnt + 1; end
        if (m0_rvalid) begin rv0_cyc <= cyc; rv0_data <= m0_rdata; rv0_err <= m0_err; rv_cnt <= rv_cnt + 1; end
        if (m1_rvalid) begin rv1_cyc <= cyc; rv1_data <= m1_rdata; rv1_err <= m1_err; rv_cnt <= rv_cnt + 1; end
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    // ---------------- requester driver (round-robin instance) ----------------
    txn_t q0 [$];
    txn_t q1 [$];
    int   pres0_cyc, pres1_cyc;

    initial begin
        logic g0, g1, popped0, popped1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        forever begin
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
            @(posedge clk);
            #1;
            popped0 = 1'b0;
            popped1 = 1'b0;
            if (!rst_n) begin
                q0.delete();
                q1.delete();
            end else begin
                if (g0 && q0.size() > 0) begin q0.delete(0); popped0 = 1'b1; end
                if (g1 && q1.size() > 0) begin q1.delete(0); popped1 = 1'b1; end
            end
            if (q0.size() > 0) begin
                if (!m0_req || popped0) pres0_cyc = cyc;
                m0_req = 1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
            end else m0_req = 0;
            if (q1.size() > 0) begin
                if (!m1_req || popped1) pres1_cyc = cyc;
                m1_req = 1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
            end else m1_req = 0;
        end
    end

    task automatic push0(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        q0.push_back(t);
    endtask

    task automatic push1(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        q1.push_back(t);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !m0_req && !m1_req && ph == 0)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                check("wait_idle_timeout", 32'd1, 32'd0);
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base_we, base_gnt, base_rv, fg0, fg1, waited;
        logic [31:0] f_rd;

        rst_n = 1'b0;
        f_m0_req = 0; f_m0_we = 0; f_m0_addr = '0; f_m0_wdata = '0;
        f_m1_req = 0; f_m1_we = 0; f_m1_addr = '0; f_m1_wdata = '0;

        repeat (2) @(negedge clk);
        check("rst_m0_gnt",   m0_gnt,   32'h0);
        check("rst_m1_rvalid", m1_rvalid, 32'h0);
        check("rst_mem_we",   mem_we,   32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Both masters contend continuously: grants alternate starting with M0.
        order.delete();
        for (int i = 0; i < 3; i++) begin
            push0(1'b1, 32'd10 + i, 32'hA000_000A + i);
            push1(1'b1, 32'd20 + i, 32'hB000_0014 + i);
        end
        wait_idle(100);
        check("rr_grant_count", order.size(), 32'd6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            check("rr_grant_order", order[i], i % 2);
        check("rr_m0_data_10", dmem0[10], 32'hA000_000A);
        check("rr_m0_data_12", dmem0[12], 32'hA000_000C);
        check("rr_m1_data_20", dmem0[20], 32'hB000_0014);
        check("rr_m1_data_22", dmem0[22], 32'hB000_0016);

        // Single write then read-back on M0, with handshake latency.
        base_we = we_cnt;
        push0(1'b1, 32'd1, 32'h9302_9203);
        wait_idle(50);
        check("wr_gnt_latency",    gnt0_cyc - pres0_cyc, 32'd1);
        check("wr_rvalid_latency", rv0_cyc - pres0_cyc,  32'd2);
        check("wr_err",            rv0_err,              32'h0);
        check("wr_rdata_zero",     rv0_data,             32'h0);
        check("wr_mem_we_pulses",  we_cnt - base_we,     32'd1);
        push0(1'b0, 32'd1, 32'h0);
        wait_idle(50);
        check("rd_back_addr1", rv0_data, 32'h9302_9203);

        // Out-of-range write from M1: no memory write, error response.
        base_we = we_cnt;
        push1(1'b1, WORDS, 32'hFFFF_FFFF);
        wait_idle(50);
        check("oor_mem_we_pulses", we_cnt - base_we, 32'd0);
        check("oor_m1_err",        rv1_err,          32'h1);
        check("oor_m1_rdata",      rv1_data,         32'h0);
        push0(1'b0, 32'd0, 32'h0);
        wait_idle(50);
        check("oor_addr0_unchanged", rv0_data, 32'h1000_0000);

        // Reset during the ACCESS cycle of a write aborts it.
        base_rv = rv_cnt;
        push0(1'b1, 32'd5, 32'hDEAD_BEEF);
        waited = 0;
        while (!m0_gnt && waited < 20) begin @(negedge clk); waited++; end
        check("abort_saw_gnt", m0_gnt, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_we",   mem_we,    32'h0);
        check("abort_m0_gnt",   m0_gnt,    32'h0);
        check("abort_mem_addr", mem_addr,  32'h0);
        check("abort_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_rvalid", rv_cnt - base_rv, 32'd0);
        check("abort_addr5_kept", dmem0[5], 32'h1000_0005);
        push0(1'b0, 32'd5, 32'h0);
        wait_idle(50);
        check("abort_rd_addr5", rv0_data, 32'h1000_0005);

        // Ten quiet cycles: nothing moves.
        base_we = we_cnt; base_gnt = gnt_cnt; base_rv = rv_cnt;
        repeat (10) @(negedge clk);
        check("idle_gnt",    gnt_cnt - base_gnt, 32'd0);
        check("idle_rvalid", rv_cnt - base_rv,   32'd0);
        check("idle_mem_we", we_cnt - base_we,   32'd0);

        // Fixed priority: M0 held high wins every access, M1 starves.
        @(posedge clk); #1;
        f_m0_req = 1; f_m0_we = 0; f_m0_addr = 32'd2;
        f_m1_req = 1; f_m1_we = 1; f_m1_addr = 32'd3; f_m1_wdata = 32'h5A5A_0003;
        fg0 = 0; fg1 = 0; f_rd = '0;
        repeat (12) begin
            @(negedge clk);
            fg0 += int'(f_m0_gnt);
            fg1 += int'(f_m1_gnt);
            if (f_m0_rvalid) f_rd = f_m0_rdata;
        end
        check("fix_m0_grants", fg0, 32'd4);
        check("fix_m1_starved", fg1, 32'd0);
        check("fix_m0_rdata", f_rd, 32'h1000_0002);
        @(posedge clk); #1;
        f_m0_req = 0;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!f_m1_gnt && waited < 8);
        check("fix_m1_gnt_after_drop", f_m1_gnt, 32'h1);
        check("fix_m1_gnt_delay", waited, 32'd2);
        @(posedge clk); #1;
        f_m1_req = 0;
        repeat (3) @(negedge clk);
        check("fix_m1_write", dmemf[3], 32'h5A5A_0003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
